maq_enc_veda_multi: RTL and testbench

Parametrised multi-channel bottle fill-and-seal controller for the filling line. It runs N_CH independent per-bottle sequencers: detect, fill with timeout, timed seal with cap confirmation, release, fault. It also keeps line-wide saturating counters of good and faulted bottles. It sits between the station sensors (PG/CH/RO per channel) and the valve drivers, and adds timing supervision and fault reporting on top of the single-station encher/vedar controller.

---
 rtl/enc_veda_pkg.sv | 25 ++
 rtl/enc_veda_channel.sv | 113 +++++++++++
 rtl/maq_enc_veda_multi.sv | 83 ++++++++
 tb/tb_maq_enc_veda_multi.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/enc_veda_pkg.sv
// Shared definitions for the multi-channel fill-and-seal controller:
// per-channel state codes, state width and a popcount helper for the line counters.
package enc_veda_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SEAL  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

  // Supports up to 64 channels; callers zero-extend their strobe vector.
  function automatic logic [7:0] popcount(input logic [63:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/enc_veda_channel.sv
// One fill/seal station: bottle sequencer FSM, supervision timer and registered
// valve/status decode. Exports done/fault strobes for the shared line counters.
module enc_veda_channel
  import enc_veda_pkg::*;
#(
  parameter int FILL_TIMEOUT = 64,
  parameter int SEAL_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               pg,
  input  logic               ch,
  input  logic               ro,
  output logic               ev,
  output logic               ve,
  output logic               err,
  output logic               gc,
  output logic [STATE_W-1:0] tipo,
  output logic               done_pulse,
  output logic               fault_enter
);

  localparam int MAX_T = (FILL_TIMEOUT > SEAL_CYCLES) ? FILL_TIMEOUT : SEAL_CYCLES;
  localparam int TW    = $clog2(MAX_T) + 1;
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] SEAL_LAST = TW'(SEAL_CYCLES - 1);

  state_e        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          ev_r, ve_r, err_r, gc_r;
  logic          done_s, fault_s;

  // Next-state, transition strobes and timer update
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pg && !ch && en) state_s = FILL;
        else                 state_s = IDLE;
      end
      FILL: begin
        // Removal beats CH, and CH beats the timeout
        if (!pg)                        state_s = IDLE;
        else if (ch)                    state_s = SEAL;
        else if (timer_r == FILL_LAST)  state_s = FAULT;
        else                            state_s = FILL;
      end
      SEAL: begin
        if (!pg) begin
          state_s = FAULT;
        end else if (timer_r == SEAL_LAST) begin
          if (ro) state_s = DONE;
          else    state_s = FAULT;
        end else begin
          state_s = SEAL;
        end
      end
      DONE: begin
        if (!pg) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DONE;
        end
      end
      FAULT: begin
        if (!pg) state_s = IDLE;
        else     state_s = FAULT;
      end
      default: state_s = IDLE;
    endcase

    fault_s = (state_s == FAULT) && (state_r != FAULT);

    if (state_s != state_r) begin
      timer_s = {TW{1'b0}};
    end else if ((state_r == FILL) || (state_r == SEAL)) begin
      timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      timer_s = timer_r;
    end
  end

  // State, timer and registered output decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= {TW{1'b0}};
      ev_r    <= 1'b0;
      ve_r    <= 1'b0;
      err_r   <= 1'b0;
      gc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      ev_r    <= (state_s == FILL);
      ve_r    <= (state_s == SEAL);
      err_r   <= (state_s == FAULT);
      gc_r    <= done_s;
    end
  end

  assign ev          = ev_r;
  assign ve          = ve_r;
  assign err         = err_r;
  assign gc          = gc_r;
  assign tipo        = state_r;
  assign done_pulse  = done_s;
  assign fault_enter = fault_s;

endmodule

// File: rtl/maq_enc_veda_multi.sv
// Multi-station fill-and-seal controller: N_CH independent channel sequencers
// plus line-wide saturating counters of released and faulted bottles.
module maq_enc_veda_multi
  import enc_veda_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int FILL_TIMEOUT = 64,
  parameter int SEAL_CYCLES  = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clr_cnt,
  input  logic [N_CH-1:0]         PG,
  input  logic [N_CH-1:0]         CH,
  input  logic [N_CH-1:0]         RO,
  output logic [N_CH-1:0]         EV,
  output logic [N_CH-1:0]         VE,
  output logic [N_CH-1:0]         GC,
  output logic [N_CH-1:0]         ERR,
  output logic [STATE_W*N_CH-1:0] tipo,
  output logic [CNT_W-1:0]        cnt_ok,
  output logic [CNT_W-1:0]        cnt_err
);

  logic [N_CH-1:0]    done_s, fault_s;
  logic [7:0]         pop_ok_s, pop_err_s;
  logic [CNT_W+7:0]   ok_sum_s, err_sum_s;
  logic [CNT_W-1:0]   cnt_ok_s, cnt_err_s;
  logic [CNT_W-1:0]   cnt_ok_r, cnt_err_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    enc_veda_channel #(
      .FILL_TIMEOUT (FILL_TIMEOUT),
      .SEAL_CYCLES  (SEAL_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .pg          (PG[i]),
      .ch          (CH[i]),
      .ro          (RO[i]),
      .ev          (EV[i]),
      .ve          (VE[i]),
      .err         (ERR[i]),
      .gc          (GC[i]),
      .tipo        (tipo[STATE_W*i +: STATE_W]),
      .done_pulse  (done_s[i]),
      .fault_enter (fault_s[i])
    );
  end

  // Saturating popcount accumulation for both line counters
  always_comb begin
    pop_ok_s  = popcount(64'(done_s));
    pop_err_s = popcount(64'(fault_s));
    ok_sum_s  = {8'd0, cnt_ok_r}  + {{CNT_W{1'b0}}, pop_ok_s};
    err_sum_s = {8'd0, cnt_err_r} + {{CNT_W{1'b0}}, pop_err_s};
    if (ok_sum_s[CNT_W+7:CNT_W] != 8'd0) cnt_ok_s = {CNT_W{1'b1}};
    else                                 cnt_ok_s = ok_sum_s[CNT_W-1:0];
    if (err_sum_s[CNT_W+7:CNT_W] != 8'd0) cnt_err_s = {CNT_W{1'b1}};
    else                                  cnt_err_s = err_sum_s[CNT_W-1:0];
  end

  // Counter registers; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_ok_r  <= {CNT_W{1'b0}};
      cnt_err_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      cnt_ok_r  <= {CNT_W{1'b0}};
      cnt_err_r <= {CNT_W{1'b0}};
    end else begin
      cnt_ok_r  <= cnt_ok_s;
      cnt_err_r <= cnt_err_s;
    end
  end

  assign cnt_ok  = cnt_ok_r;
  assign cnt_err = cnt_err_r;

endmodule

// File: tb/tb_maq_enc_veda_multi.sv
// Directed bench for maq_enc_veda_multi (2 channels, timeout 8, seal 3, 4-bit counters):
// a vector table for the basic cycle plus hand sequences for timing corner cases.
module tb_maq_enc_veda_multi;

  logic       clk = 1'b0;
  logic       reset, en, clr_cnt;
  logic [1:0] PG, CH, RO;
  logic [1:0] EV, VE, GC, ERR;
  logic [5:0] tipo;
  logic [3:0] cnt_ok, cnt_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, clr;
    logic [1:0] pg, ch, ro;
    logic [1:0] ev, ve, gc, err;
    logic [5:0] tipo;
    logic [3:0] ok, er;
    string      name;
  } vec_t;

  vec_t vecs[15];

  maq_enc_veda_multi #(
    .N_CH(2), .FILL_TIMEOUT(8), .SEAL_CYCLES(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clr_cnt(clr_cnt),
    .PG(PG), .CH(CH), .RO(RO),
    .EV(EV), .VE(VE), .GC(GC), .ERR(ERR),
    .tipo(tipo), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic e, input logic c, input logic [1:0] p,
                     input logic [1:0] h, input logic [1:0] r);
    en = e; clr_cnt = c; PG = p; CH = h; RO = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [1:0] e_ev, input logic [1:0] e_ve,
                       input logic [1:0] e_gc, input logic [1:0] e_err,
                       input logic [5:0] e_tipo, input logic [3:0] e_ok, input logic [3:0] e_er);
    checks++;
    if ({EV, VE, GC, ERR, tipo, cnt_ok, cnt_err} !== {e_ev, e_ve, e_gc, e_err, e_tipo, e_ok, e_er}) begin
      errors++;
      $display("FAIL %s: got ev=%b ve=%b gc=%b err=%b tipo=%b ok=%0d er=%0d, want ev=%b ve=%b gc=%b err=%b tipo=%b ok=%0d er=%0d",
               nm, EV, VE, GC, ERR, tipo, cnt_ok, cnt_err,
               e_ev, e_ve, e_gc, e_err, e_tipo, e_ok, e_er);
    end
  endtask

  // Both channels through a full good cycle; release edge optionally carries clr_cnt
  task automatic release_both(input logic clr, input logic [3:0] p_ok, input logic [3:0] p_er,
                              input logic [3:0] x_ok, input logic [3:0] x_er);
    cyc(1'b1, 1'b0, 2'b11, 2'b00, 2'b00);
    check("rel_fill", 2'b11, 2'b00, 2'b00, 2'b00, 6'b001001, p_ok, p_er);
    cyc(1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
    check("rel_seal", 2'b00, 2'b11, 2'b00, 2'b00, 6'b010010, p_ok, p_er);
    cyc(1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
    cyc(1'b1, 1'b0, 2'b11, 2'b11, 2'b00);
    check("rel_seal3", 2'b00, 2'b11, 2'b00, 2'b00, 6'b010010, p_ok, p_er);
    cyc(1'b1, 1'b0, 2'b11, 2'b11, 2'b11);
    check("rel_done", 2'b00, 2'b00, 2'b00, 2'b00, 6'b011011, p_ok, p_er);
    cyc(1'b1, clr, 2'b00, 2'b00, 2'b00);
    check("rel_gc", 2'b00, 2'b00, 2'b11, 2'b00, 6'b000000, x_ok, x_er);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("rel_gc_end", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, x_ok, x_er);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd0, 4'd0, "idle"};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd0, 4'd0, "fill1"};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd0, 4'd0, "fill2"};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd0, 4'd0, "fill3"};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd0, 4'd0, "fill4"};
    vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd0, 4'd0, "seal1"};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd0, 4'd0, "seal2"};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd0, 4'd0, "seal3"};
    vecs[8]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000011, 4'd0, 4'd0, "done"};
    vecs[9]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000011, 4'd0, 4'd0, "done_hold"};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 6'b000000, 4'd1, 4'd0, "release"};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd0, "gc_one_cycle"};
    vecs[12] = '{1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd0, "en_gate"};
    vecs[13] = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd0, "prefilled"};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd0, "idle_end"};

    reset = 1'b1; en = 1'b0; clr_cnt = 1'b0; PG = 2'b00; CH = 2'b00; RO = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].en, vecs[i].clr, vecs[i].pg, vecs[i].ch, vecs[i].ro);
      check(vecs[i].name, vecs[i].ev, vecs[i].ve, vecs[i].gc, vecs[i].err,
            vecs[i].tipo, vecs[i].ok, vecs[i].er);
    end

    // ch1 fill timeout, with en dropped mid-FILL
    cyc(1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
    check("to_fill1", 2'b10, 2'b00, 2'b00, 2'b00, 6'b001000, 4'd1, 4'd0);
    for (int k = 2; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 2'b10, 2'b00, 2'b00);
      check("to_fill_n", 2'b10, 2'b00, 2'b00, 2'b00, 6'b001000, 4'd1, 4'd0);
    end
    cyc(1'b0, 1'b0, 2'b10, 2'b00, 2'b00);
    check("to_fault", 2'b00, 2'b00, 2'b00, 2'b10, 6'b100000, 4'd1, 4'd1);
    cyc(1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
    check("to_fault_hold", 2'b00, 2'b00, 2'b00, 2'b10, 6'b100000, 4'd1, 4'd1);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("to_remove", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd1);

    // ch0: CH on the timeout cycle goes to SEAL, then RO missing at end of seal
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    end
    check("edge_fill8", 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd1, 4'd1);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    check("ch_on_timeout", 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd1, 4'd1);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    check("sf_seal3", 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd1, 4'd1);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    check("seal_no_ro", 2'b00, 2'b00, 2'b00, 2'b01, 6'b000100, 4'd1, 4'd2);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("sf_remove", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd2);

    // ch0: removal together with the timeout edge aborts without fault
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    end
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("pg_drop_on_timeout", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd2);

    // ch1: bottle removed during SEAL
    cyc(1'b1, 1'b0, 2'b10, 2'b00, 2'b00);
    cyc(1'b1, 1'b0, 2'b10, 2'b10, 2'b00);
    check("pd_seal", 2'b00, 2'b10, 2'b00, 2'b00, 6'b010000, 4'd1, 4'd2);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("pg_drop_seal", 2'b00, 2'b00, 2'b00, 2'b10, 6'b100000, 4'd1, 4'd3);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    check("pd_idle", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd1, 4'd3);

    // simultaneous releases up to saturation, then clear against an increment
    for (int k = 0; k < 7; k++) begin
      release_both(1'b0, 4'(1 + 2*k), 4'd3, 4'(3 + 2*k), 4'd3);
    end
    release_both(1'b0, 4'd15, 4'd3, 4'd15, 4'd3);
    release_both(1'b1, 4'd15, 4'd3, 4'd0, 4'd0);
    release_both(1'b0, 4'd0, 4'd0, 4'd2, 4'd0);

    // async reset mid-SEAL
    cyc(1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    check("pre_reset_seal", 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd2, 4'd0);
    #1 reset = 1'b1;
    #1;
    check("async_reset", 2'b00, 2'b00, 2'b00, 2'b00, 6'b000000, 4'd0, 4'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, 1'b0, 2'b01, 2'b00, 2'b00);
    check("post_reset_fill", 2'b01, 2'b00, 2'b00, 2'b00, 6'b000001, 4'd0, 4'd0);
    cyc(1'b1, 1'b0, 2'b01, 2'b01, 2'b00);
    check("post_reset_seal", 2'b00, 2'b01, 2'b00, 2'b00, 6'b000010, 4'd0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
